lal_sched: RTL and testbench

Round-robin scheduler that shares one instance of the `lal` combinational decode datapath (26 inputs, 19 outputs) between NREQ requesters. It arbitrates requests and registers the winning operand onto the datapath inputs. It then waits a fixed multicycle settle window, captures the datapath outputs, and returns them with the requester ID over a valid/ready response port. It sits between the requester front-ends and the shared `lal` instance.

---
 rtl/lal_sched.sv | 140 ++++++++++++++
 tb/tb_lal_sched.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lal_sched.sv
// Round-robin scheduler sharing one combinational lal datapath between NREQ requesters.
// Each transaction allows a fixed multicycle settle window before the result is captured.
module lal_sched #(
    parameter int NREQ        = 4,
    parameter int IW          = 26,
    parameter int OW          = 19,
    parameter int EVAL_CYCLES = 2,
    parameter int IDW         = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*IW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [IW-1:0]        dp_in,
    input  logic [OW-1:0]        dp_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [OW-1:0]        rsp_data,
    output logic                 busy
);

    localparam int CW = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(EVAL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        HOLD
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [IDW-1:0]  r_ptr;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_dpIn;
    logic            r_rspValid;
    logic [IDW-1:0]  r_rspId;
    logic [OW-1:0]   r_rspData;
    logic [IDW-1:0]  w_winner;
    logic            w_anyReq;

    generate
        if (EVAL_CYCLES < 1) begin : g_badEvalCycles
            $error("lal_sched: EVAL_CYCLES must be at least 1");
        end
    endgenerate

    // Scan downward in offset so the set bit closest to r_ptr is the last one written.
    always_comb begin
        int idx;
        idx      = 0;
        w_anyReq = 1'b0;
        w_winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(r_ptr) + i) % NREQ;
            if (req[IDW'(idx)]) begin
                w_anyReq = 1'b1;
                w_winner = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        gnt         = '0;
        case (r_state)
            IDLE: begin
                if (w_anyReq && rst_n) begin
                    gnt[w_winner] = 1'b1;
                    w_nextState   = EVAL;
                end
            end
            EVAL: begin
                if (r_cnt == '0) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // dp_in only moves on a grant so the shared datapath stays quiet while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_dpIn     <= '0;
            r_rspValid <= 1'b0;
            r_rspId    <= '0;
            r_rspData  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_dpIn  <= req_data[w_winner*IW +: IW];
                        r_rspId <= w_winner;
                        r_ptr   <= (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + 1'b1;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                EVAL: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rspData  <= dp_out;
                        r_rspValid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dp_in     = r_dpIn;
    assign rsp_valid = r_rspValid;
    assign rsp_id    = r_rspId;
    assign rsp_data  = r_rspData;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_lal_sched.sv
// Bench for lal_sched: a transaction-timeline model predicts every output each cycle,
// plus a second instance built with EVAL_CYCLES=1 for the fast-throughput case.
module tb_lal_sched;
    localparam int NREQ = 4;
    localparam int IW   = 26;
    localparam int OW   = 19;
    localparam int EC   = 2;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rstN = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*IW-1:0]  reqData = '0;
    logic [NREQ-1:0]     gnt;
    logic [IW-1:0]       dpIn;
    logic [OW-1:0]       dpOut;
    logic                rspValid;
    logic                rspReady = 1'b1;
    logic [IDW-1:0]      rspId;
    logic [OW-1:0]       rspData;
    logic                busy;

    logic [NREQ-1:0]     req1 = '0;
    logic [NREQ*IW-1:0]  reqData1 = '0;
    logic [NREQ-1:0]     gnt1;
    logic [IW-1:0]       dpIn1;
    logic [OW-1:0]       dpOut1;
    logic                rspValid1;
    logic                rspReady1 = 1'b1;
    logic [IDW-1:0]      rspId1;
    logic [OW-1:0]       rspData1;
    logic                busy1;

    int totalChecks = 0;
    int badChecks   = 0;

    // Stand-in for the shared lal decode datapath.
    function automatic logic [OW-1:0] lalModel(input logic [IW-1:0] x);
        return (x[18:0] ^ {x[25:19], x[25:14]}) + 19'h12345;
    endfunction

    assign dpOut  = lalModel(dpIn);
    assign dpOut1 = lalModel(dpIn1);

    lal_sched #(.NREQ(NREQ), .IW(IW), .OW(OW), .EVAL_CYCLES(EC)) dut (
        .clk(clk), .rst_n(rstN), .req(req), .req_data(reqData), .gnt(gnt),
        .dp_in(dpIn), .dp_out(dpOut), .rsp_valid(rspValid), .rsp_ready(rspReady),
        .rsp_id(rspId), .rsp_data(rspData), .busy(busy)
    );

    lal_sched #(.NREQ(NREQ), .IW(IW), .OW(OW), .EVAL_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rstN), .req(req1), .req_data(reqData1), .gnt(gnt1),
        .dp_in(dpIn1), .dp_out(dpOut1), .rsp_valid(rspValid1), .rsp_ready(rspReady1),
        .rsp_id(rspId1), .rsp_data(rspData1), .busy(busy1)
    );

    // Model: mPhase counts cycles since the grant (0 = idle, EC+1 = holding a response).
    int              mPtr, mPhase, mId, lastWin;
    logic [IW-1:0]   mDpIn;
    logic [OW-1:0]   mRsp;
    logic [IW-1:0]   opData [NREQ];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalChecks++;
        if (obs !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int pickWinner(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mPtr = 0; mPhase = 0; mId = 0; mDpIn = '0; mRsp = '0; lastWin = -1;
    endtask

    // Entered and left at posedge+1; drives one cycle, checks, advances the model.
    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic rdy);
        int w;
        logic [NREQ-1:0] expG;
        req = r;
        rspReady = rdy;
        for (int i = 0; i < NREQ; i++) reqData[i*IW +: IW] = opData[i];
        #1;
        w = (mPhase == 0) ? pickWinner(r, mPtr) : -1;
        expG = (w >= 0) ? NREQ'(1 << w) : '0;
        checkOutput("gnt", 32'(gnt), 32'(expG));
        checkOutput("dp_in", 32'(dpIn), 32'(mDpIn));
        checkOutput("busy", 32'(busy), 32'(mPhase != 0));
        checkOutput("rsp_valid", 32'(rspValid), 32'(mPhase == EC + 1));
        checkOutput("rsp_id", 32'(rspId), 32'(mId));
        checkOutput("rsp_data", 32'(rspData), 32'(mRsp));
        if (w >= 0) begin
            mDpIn = opData[w]; mId = w; mPtr = (w + 1) % NREQ; mPhase = 1;
        end else if (mPhase >= 1 && mPhase <= EC) begin
            if (mPhase == EC) mRsp = lalModel(mDpIn);
            mPhase++;
        end else if (mPhase == EC + 1 && rdy) begin
            mPhase = 0;
        end
        lastWin = w;
        @(posedge clk); #1;
    endtask

    // Asserts reset between edges and checks outputs clear with no clock edge in between.
    task automatic applyReset();
        rstN = 1'b0;
        req = '1;
        #1;
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_dp_in", 32'(dpIn), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_rsp_valid", 32'(rspValid), 32'h0);
        checkOutput("rst_rsp_id", 32'(rspId), 32'h0);
        checkOutput("rst_rsp_data", 32'(rspData), 32'h0);
        req = '0;
        modelReset();
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [NREQ-1:0] rv;
        logic [IW-1:0]   op1;
        logic [OW-1:0]   exp1;
        opData[0] = 26'h1111111;
        opData[1] = 26'h0ABCDEF;
        opData[2] = 26'h2A55A5A;
        opData[3] = 26'h3C3C3C3;
        modelReset();
        #2;
        applyReset();

        // Single request from requester 2, then idle until the response drains.
        applyStimulus(4'b0100, 1'b1);
        for (int c = 0; c < 5; c++) applyStimulus(4'b0000, 1'b1);

        // Full-load rotation from ptr=0: 0,1,2,3,0,1.
        applyReset();
        for (int c = 0; c < 24; c++) applyStimulus(4'b1111, 1'b1);

        // ptr=1 with 1001 pending: 3 then 0.
        applyReset();
        applyStimulus(4'b0001, 1'b1);
        for (int c = 0; c < 9; c++) applyStimulus(4'b1001, 1'b1);

        // Back-pressure: six stalled HOLD cycles, then release.
        for (int c = 0; c < 4; c++) applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0011, 1'b1);
        for (int c = 0; c < 8; c++) applyStimulus(4'b0011, 1'b0);
        for (int c = 0; c < 5; c++) applyStimulus(4'b0011, 1'b1);

        // Reset while the counter is still 1; the abandoned response must never show.
        for (int c = 0; c < 6; c++) applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0100, 1'b1);
        applyReset();
        applyStimulus(4'b0010, 1'b1);
        for (int c = 0; c < 6; c++) applyStimulus(4'b0000, 1'b1);

        // Random requests, drops, operand changes after grant, and random back-pressure.
        rv = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!rv[i] || lastWin == i) begin
                    rv[i] = ($urandom_range(0, 2) != 0);
                    opData[i] = IW'($urandom);
                end else if ($urandom_range(0, 9) == 0) begin
                    rv[i] = 1'b0;
                end
            end
            applyStimulus(rv, ($urandom_range(0, 3) != 0));
        end

        // EVAL_CYCLES=1 instance: grant every 3 cycles on an incrementing operand stream.
        applyReset();
        op1 = 26'h0100000;
        exp1 = '0;
        for (int c = 0; c < 15; c++) begin
            req1 = 4'b0001;
            reqData1 = '0;
            reqData1[IW-1:0] = op1;
            #1;
            checkOutput("gnt_ec1", 32'(gnt1), 32'(c % 3 == 0));
            checkOutput("valid_ec1", 32'(rspValid1), 32'(c % 3 == 2));
            if (c % 3 == 2) checkOutput("data_ec1", 32'(rspData1), 32'(exp1));
            if (c % 3 == 0) begin
                exp1 = lalModel(op1);
                op1 = op1 + 1'b1;
            end
            @(posedge clk); #1;
        end
        req1 = '0;

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end
endmodule
